uart_rx_fifo: RTL and testbench

UART_RX_FIFO -- requirements
Module: uart_rx_fifo

---
 rtl/uart_pkg.sv | 40 ++++
 rtl/uart_rx_fifo_if.sv | 9 +
 rtl/uart_rx_fifo_buf.sv | 62 ++++++
 rtl/uart_rx_fifo.sv | 212 +++++++++++++++++++++
 tb/tb_uart_rx_fifo.sv | 306 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared types and constants for the UART receiver with FIFO.
package uart_pkg;

  // Receiver frame states
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } rx_state_e;

  // cfg_bits encoding
  localparam logic [1:0] BITS_5 = 2'b00;
  localparam logic [1:0] BITS_6 = 2'b01;
  localparam logic [1:0] BITS_7 = 2'b10;
  localparam logic [1:0] BITS_8 = 2'b11;

  // Idle bit periods before the receive timeout fires
  localparam int IDLE_TIMEOUT_BITS = 32;

  // Number of data bits for a cfg_bits code
  function automatic logic [3:0] data_len(input logic [1:0] bits);
    logic [3:0] len;
    case (bits)
      BITS_5:  len = 4'd5;
      BITS_6:  len = 4'd6;
      BITS_7:  len = 4'd7;
      BITS_8:  len = 4'd8;
      default: len = 4'd8;
    endcase
    return len;
  endfunction

  // Expected parity bit; unused upper bits of data must be zero
  function automatic logic parity_bit(input logic [7:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/uart_rx_fifo_if.sv
// uart_rx_fifo_if: received-byte stream handshake (FIFO head data, valid, ready).
interface uart_rx_fifo_if;
  logic [7:0] rx_data_o;
  logic       rx_valid_o;
  logic       rx_ready_i;

  modport master (output rx_data_o, output rx_valid_o, input rx_ready_i);
  modport slave  (input rx_data_o, input rx_valid_o, output rx_ready_i);
endinterface

// File: rtl/uart_rx_fifo_buf.sv
// uart_rx_fifo_buf: first-word fall-through FIFO. A push into a full FIFO is
// accepted only when a pop happens in the same cycle; no empty-FIFO bypass.
module uart_rx_fifo_buf #(
  parameter int FIFO_DEPTH = 8,
  parameter int WIDTH      = 8
) (
  input  logic                        clk_i,
  input  logic                        rstn_i,
  input  logic                        push_i,
  input  logic [WIDTH-1:0]            data_i,
  input  logic                        pop_i,
  output logic [WIDTH-1:0]            data_o,
  output logic [$clog2(FIFO_DEPTH):0] level_o,
  output logic                        full_o,
  output logic                        empty_o
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] DEPTH_L = (AW+1)'(FIFO_DEPTH);

  logic [WIDTH-1:0] r_mem [FIFO_DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_level;
  logic             w_do_push;
  logic             w_do_pop;

  assign full_o    = (r_level == DEPTH_L);
  assign empty_o   = (r_level == (AW+1)'(0));
  assign w_do_pop  = pop_i && !empty_o;
  assign w_do_push = push_i && (!full_o || w_do_pop);
  assign level_o   = r_level;
  assign data_o    = empty_o ? WIDTH'(0) : r_mem[r_rd_ptr];

  // Storage write; cleared on reset so the head output is defined
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_mem[i] <= WIDTH'(0);
      end
    end else if (w_do_push) begin
      r_mem[r_wr_ptr] <= data_i;
    end
  end

  // Pointers (natural wrap) and occupancy
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_wr_ptr <= AW'(0);
      r_rd_ptr <= AW'(0);
      r_level  <= (AW+1)'(0);
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_level <= r_level + (AW+1)'(1);
        2'b01:   r_level <= r_level - (AW+1)'(1);
        default: r_level <= r_level;
      endcase
    end
  end

endmodule

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: UART receiver (5..8 data bits, optional parity, 1/2 stop bits)
// feeding a receive FIFO, with sticky error flags.
// Optional feature: define UART_RX_TIMEOUT_EN to build the idle receive timeout;
// otherwise rx_timeout_o is tied low.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int DIV_W      = 16
) (
  input  logic                        clk_i,
  input  logic                        rstn_i,
  input  logic                        rx_i,
  input  logic                        cfg_en_i,
  input  logic [DIV_W-1:0]            cfg_div_i,
  input  logic [1:0]                  cfg_bits_i,
  input  logic                        cfg_parity_en_i,
  input  logic                        cfg_parity_odd_i,
  input  logic                        cfg_stop2_i,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level_o,
  output logic                        busy_o,
  output logic                        err_parity_o,
  output logic                        err_frame_o,
  output logic                        err_overflow_o,
  input  logic                        err_clr_i,
  output logic                        rx_timeout_o,
  uart_rx_fifo_if.master              rx_if
);

  logic             r_sync1, r_sync2, r_rx_prev;
  rx_state_e        r_state;
  logic [DIV_W-1:0] r_cnt, r_div;
  logic [2:0]       r_bit_idx;
  logic [7:0]       r_shift;
  logic [3:0]       r_len;
  logic             r_par_en, r_par_odd, r_stop2, r_stop_idx;
  logic             r_par_bad, r_frame_bad;
  logic             r_err_par, r_err_frm, r_err_ovf;

  logic             w_rx, w_start, w_tick, w_active_tick;
  logic             w_par_err, w_stop_samp, w_frm_err, w_last_stop;
  logic             w_push, w_pop, w_ovf, w_full, w_empty;
  logic [7:0]       w_byte;

  assign w_rx          = r_sync2;
  assign w_start       = (r_state == ST_IDLE) && cfg_en_i && r_rx_prev && !w_rx;
  assign w_active_tick = w_tick && cfg_en_i;
  assign w_par_err     = (r_state == ST_PARITY) && w_active_tick &&
                         (w_rx != parity_bit(r_shift, r_par_odd));
  assign w_stop_samp   = (r_state == ST_STOP) && w_active_tick;
  assign w_frm_err     = w_stop_samp && !w_rx;
  assign w_last_stop   = w_stop_samp && (!r_stop2 || r_stop_idx);
  assign w_push        = w_last_stop && w_rx && !r_frame_bad && !r_par_bad;
  // Data was shifted in from the top; right-align it to the LSB
  assign w_byte        = r_shift >> (4'd8 - r_len);
  assign w_pop         = rx_if.rx_valid_o && rx_if.rx_ready_i;
  assign w_ovf         = w_push && w_full && !w_pop;

  assign rx_if.rx_valid_o = !w_empty;
  assign busy_o           = (r_state != ST_IDLE);
  assign err_parity_o     = r_err_par;
  assign err_frame_o      = r_err_frm;
  assign err_overflow_o   = r_err_ovf;

  // Sample point: half a bit into the start bit, then one full bit per sample
  always_comb begin
    w_tick = 1'b0;
    case (r_state)
      ST_START:                    w_tick = (r_cnt == (r_div >> 1) - DIV_W'(1));
      ST_DATA, ST_PARITY, ST_STOP: w_tick = (r_cnt == r_div - DIV_W'(1));
      default:                     w_tick = 1'b0;
    endcase
  end

  // Two-flop synchroniser plus previous value for falling-edge detection
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_sync1   <= 1'b1;
      r_sync2   <= 1'b1;
      r_rx_prev <= 1'b1;
    end else begin
      r_sync1   <= rx_i;
      r_sync2   <= r_sync1;
      r_rx_prev <= r_sync2;
    end
  end

  // Frame FSM: latches the configuration at start, shifts data, tracks errors
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_state     <= ST_IDLE;
      r_cnt       <= DIV_W'(0);
      r_div       <= DIV_W'(0);
      r_bit_idx   <= 3'd0;
      r_shift     <= 8'd0;
      r_len       <= 4'd8;
      r_par_en    <= 1'b0;
      r_par_odd   <= 1'b0;
      r_stop2     <= 1'b0;
      r_stop_idx  <= 1'b0;
      r_par_bad   <= 1'b0;
      r_frame_bad <= 1'b0;
    end else if ((r_state != ST_IDLE) && !cfg_en_i) begin
      r_state <= ST_IDLE;
      r_cnt   <= DIV_W'(0);
    end else begin
      r_cnt <= w_tick ? DIV_W'(0) : r_cnt + DIV_W'(1);
      case (r_state)
        ST_IDLE: begin
          r_cnt <= DIV_W'(0);
          if (w_start) begin
            r_state     <= ST_START;
            r_div       <= cfg_div_i;
            r_len       <= data_len(cfg_bits_i);
            r_par_en    <= cfg_parity_en_i;
            r_par_odd   <= cfg_parity_odd_i;
            r_stop2     <= cfg_stop2_i;
            r_bit_idx   <= 3'd0;
            r_shift     <= 8'd0;
            r_stop_idx  <= 1'b0;
            r_par_bad   <= 1'b0;
            r_frame_bad <= 1'b0;
          end
        end
        ST_START: begin
          if (w_tick) r_state <= w_rx ? ST_IDLE : ST_DATA;
        end
        ST_DATA: begin
          if (w_tick) begin
            r_shift <= {w_rx, r_shift[7:1]};
            if ({1'b0, r_bit_idx} == (r_len - 4'd1)) begin
              r_state <= r_par_en ? ST_PARITY : ST_STOP;
            end else begin
              r_bit_idx <= r_bit_idx + 3'd1;
            end
          end
        end
        ST_PARITY: begin
          if (w_tick) begin
            r_par_bad <= (w_rx != parity_bit(r_shift, r_par_odd));
            r_state   <= ST_STOP;
          end
        end
        ST_STOP: begin
          if (w_tick) begin
            r_frame_bad <= r_frame_bad | ~w_rx;
            if (r_stop2 && !r_stop_idx) r_stop_idx <= 1'b1;
            else                        r_state    <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Sticky error flags; a set in the same cycle as a clear wins
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_err_par <= 1'b0;
      r_err_frm <= 1'b0;
      r_err_ovf <= 1'b0;
    end else begin
      r_err_par <= w_par_err ? 1'b1 : (err_clr_i ? 1'b0 : r_err_par);
      r_err_frm <= w_frm_err ? 1'b1 : (err_clr_i ? 1'b0 : r_err_frm);
      r_err_ovf <= w_ovf     ? 1'b1 : (err_clr_i ? 1'b0 : r_err_ovf);
    end
  end

  uart_rx_fifo_buf #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .WIDTH      (8)
  ) u_buf (
    .clk_i   (clk_i),
    .rstn_i  (rstn_i),
    .push_i  (w_push),
    .data_i  (w_byte),
    .pop_i   (w_pop),
    .data_o  (rx_if.rx_data_o),
    .level_o (fifo_level_o),
    .full_o  (w_full),
    .empty_o (w_empty)
  );

`ifdef UART_RX_TIMEOUT_EN
  logic [DIV_W+5:0] r_to_cnt;
  logic             r_timeout;
  logic [DIV_W+5:0] w_to_limit;

  assign w_to_limit   = (DIV_W+6)'(cfg_div_i) * (DIV_W+6)'(IDLE_TIMEOUT_BITS);
  assign rx_timeout_o = r_timeout;

  // Idle timeout: counts idle cycles while data waits in the FIFO
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_to_cnt  <= (DIV_W+6)'(0);
      r_timeout <= 1'b0;
    end else if (w_pop || w_start) begin
      r_to_cnt  <= (DIV_W+6)'(0);
      r_timeout <= 1'b0;
    end else if ((r_state != ST_IDLE) || w_empty) begin
      r_to_cnt  <= (DIV_W+6)'(0);
    end else if (r_to_cnt >= w_to_limit - (DIV_W+6)'(1)) begin
      r_timeout <= 1'b1;
    end else begin
      r_to_cnt  <= r_to_cnt + (DIV_W+6)'(1);
    end
  end
`else
  assign rx_timeout_o = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: directed scenarios plus randomized frames checked against a
// queue-based reference model of the receiver and FIFO.
module tb_uart_rx_fifo;
  localparam int DEPTH = 8;

  logic       clk = 1'b0;
  logic       rstn_i = 1'b0;
  logic       rx_i = 1'b1;
  logic       cfg_en_i = 1'b0;
  logic [15:0] cfg_div_i = 16'd16;
  logic [1:0] cfg_bits_i = 2'b11;
  logic       cfg_parity_en_i = 1'b0;
  logic       cfg_parity_odd_i = 1'b0;
  logic       cfg_stop2_i = 1'b0;
  logic       err_clr_i = 1'b0;
  logic [3:0] fifo_level_o;
  logic       busy_o, err_parity_o, err_frame_o, err_overflow_o, rx_timeout_o;

  uart_rx_fifo_if u_if ();

  uart_rx_fifo #(.FIFO_DEPTH(DEPTH), .DIV_W(16)) dut (
    .clk_i(clk), .rstn_i(rstn_i), .rx_i(rx_i), .cfg_en_i(cfg_en_i),
    .cfg_div_i(cfg_div_i), .cfg_bits_i(cfg_bits_i),
    .cfg_parity_en_i(cfg_parity_en_i), .cfg_parity_odd_i(cfg_parity_odd_i),
    .cfg_stop2_i(cfg_stop2_i), .fifo_level_o(fifo_level_o), .busy_o(busy_o),
    .err_parity_o(err_parity_o), .err_frame_o(err_frame_o),
    .err_overflow_o(err_overflow_o), .err_clr_i(err_clr_i),
    .rx_timeout_o(rx_timeout_o), .rx_if(u_if)
  );

  always #5 clk = ~clk;

  int         n_chk = 0;
  int         n_fail = 0;
  int         cur_div = 16;
  logic [7:0] q[$];
  bit         exp_par = 1'b0, exp_frm = 1'b0, exp_ovf = 1'b0;
  bit         to_en;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_cfg(input int dv, input logic [1:0] bb, input bit pe, input bit po, input bit s2);
    @(negedge clk);
    cfg_div_i = 16'(dv);
    cfg_bits_i = bb;
    cfg_parity_en_i = pe;
    cfg_parity_odd_i = po;
    cfg_stop2_i = s2;
    cur_div = dv;
  endtask

  task automatic drive_bit(input logic b);
    rx_i = b;
    repeat (cur_div) @(negedge clk);
  endtask

  // Serial frame from the current configuration; fl flips parity, b1/b2 zero a stop bit
  task automatic send_frame(input logic [7:0] d, input bit fl, input bit b1, input bit b2);
    int nb;
    logic par;
    nb = 5 + int'(cfg_bits_i);
    par = cfg_parity_odd_i ^ fl;
    for (int i = 0; i < nb; i++) par = par ^ d[i];
    drive_bit(1'b0);
    for (int i = 0; i < nb; i++) drive_bit(d[i]);
    if (cfg_parity_en_i) drive_bit(par);
    drive_bit(!b1);
    if (cfg_stop2_i) drive_bit(!b2);
    drive_bit(1'b1);
  endtask

  task automatic model_frame(input logic [7:0] d, input bit fl, input bit b1, input bit b2);
    int nb;
    bit perr, ferr;
    logic [7:0] m;
    nb = 5 + int'(cfg_bits_i);
    m = 8'((16'd1 << nb) - 16'd1);
    perr = cfg_parity_en_i && fl;
    ferr = b1 || (cfg_stop2_i && b2);
    if (perr) exp_par = 1'b1;
    if (ferr) exp_frm = 1'b1;
    if (!perr && !ferr) begin
      if (q.size() < DEPTH) q.push_back(d & m);
      else exp_ovf = 1'b1;
    end
  endtask

  task automatic check_all(input string tag);
    check_eq({tag, "_level"}, 32'(fifo_level_o), 32'(q.size()));
    check_eq({tag, "_valid"}, 32'(u_if.rx_valid_o), 32'(q.size() != 0));
    check_eq({tag, "_data"}, 32'(u_if.rx_data_o), (q.size() != 0) ? 32'(q[0]) : 32'd0);
    check_eq({tag, "_errpar"}, 32'(err_parity_o), 32'(exp_par));
    check_eq({tag, "_errfrm"}, 32'(err_frame_o), 32'(exp_frm));
    check_eq({tag, "_errovf"}, 32'(err_overflow_o), 32'(exp_ovf));
    check_eq({tag, "_busy"}, 32'(busy_o), 32'd0);
  endtask

  task automatic drain(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      check_eq({tag, "_drain_valid"}, 32'(u_if.rx_valid_o), 32'd1);
      check_eq({tag, "_drain_data"}, 32'(u_if.rx_data_o), 32'(q[0]));
      u_if.rx_ready_i = 1'b1;
      @(negedge clk);
      u_if.rx_ready_i = 1'b0;
      void'(q.pop_front());
    end
    check_eq({tag, "_drain_level"}, 32'(fifo_level_o), 32'(q.size()));
  endtask

  task automatic clear_err();
    @(negedge clk);
    err_clr_i = 1'b1;
    @(negedge clk);
    err_clr_i = 1'b0;
    exp_par = 1'b0; exp_frm = 1'b0; exp_ovf = 1'b0;
  endtask

  task automatic check_reset_vals(input string tag);
    check_eq({tag, "_level"}, 32'(fifo_level_o), 32'd0);
    check_eq({tag, "_valid"}, 32'(u_if.rx_valid_o), 32'd0);
    check_eq({tag, "_data"}, 32'(u_if.rx_data_o), 32'd0);
    check_eq({tag, "_busy"}, 32'(busy_o), 32'd0);
    check_eq({tag, "_errs"}, 32'({err_parity_o, err_frame_o, err_overflow_o}), 32'd0);
    check_eq({tag, "_timeout"}, 32'(rx_timeout_o), 32'd0);
  endtask

  initial begin
`ifdef UART_RX_TIMEOUT_EN
    to_en = 1'b1;
`else
    to_en = 1'b0;
`endif
    u_if.rx_ready_i = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    check_reset_vals("rst_hold");
    rstn_i = 1'b1;
    cfg_en_i = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_vals("rst_release");

    // 8N1 0x55 at div 104: valid and level rise together inside the stop bit
    set_cfg(104, 2'b11, 1'b0, 1'b0, 1'b0);
    fork
      send_frame(8'h55, 1'b0, 1'b0, 1'b0);
      begin
        int n;
        n = 0;
        while (u_if.rx_valid_o !== 1'b1 && n < 3000) begin
          @(negedge clk);
          n++;
        end
        check_eq("8n1_valid_in_stop_window", 32'((n >= 9 * 104 + 52) && (n <= 9 * 104 + 58)), 32'd1);
        check_eq("8n1_level_with_valid", 32'(fifo_level_o), 32'd1);
        check_eq("8n1_data_with_valid", 32'(u_if.rx_data_o), 32'h55);
      end
    join
    model_frame(8'h55, 1'b0, 1'b0, 1'b0);
    check_all("8n1");
    drain("8n1", 1);

    // 7E1: good 0x2A then 0x2A with flipped parity
    set_cfg(104, 2'b10, 1'b1, 1'b0, 1'b0);
    send_frame(8'h2A, 1'b0, 1'b0, 1'b0);
    model_frame(8'h2A, 1'b0, 1'b0, 1'b0);
    send_frame(8'h2A, 1'b1, 1'b0, 1'b0);
    model_frame(8'h2A, 1'b1, 1'b0, 1'b0);
    check_eq("7e1_level", 32'(fifo_level_o), 32'd1);
    check_eq("7e1_errpar", 32'(err_parity_o), 32'd1);
    check_all("7e1");
    drain("7e1", 1);
    clear_err();
    check_all("7e1_clr");

    // Overflow: 9 bytes into a depth-8 FIFO with no pops
    set_cfg(16, 2'b11, 1'b0, 1'b0, 1'b0);
    for (int i = 1; i <= 9; i++) begin
      send_frame(8'(i), 1'b0, 1'b0, 1'b0);
      model_frame(8'(i), 1'b0, 1'b0, 1'b0);
    end
    check_eq("ovf_level", 32'(fifo_level_o), 32'd8);
    check_eq("ovf_flag", 32'(err_overflow_o), 32'd1);
    check_all("ovf");
    repeat (600) @(negedge clk);
    check_eq("timeout_idle", 32'(rx_timeout_o), 32'(to_en));
    check_eq("ovf_head_first", 32'(u_if.rx_data_o), 32'h01);
    drain("ovf", 8);
    check_eq("timeout_after_pop", 32'(rx_timeout_o), 32'd0);
    clear_err();

    // 30-cycle glitch at div 104: busy for half a bit, no push, no error
    set_cfg(104, 2'b11, 1'b0, 1'b0, 1'b0);
    fork
      begin
        rx_i = 1'b0;
        repeat (30) @(negedge clk);
        rx_i = 1'b1;
      end
      begin
        int k, n;
        k = 0;
        n = 0;
        while (busy_o !== 1'b1 && k < 20) begin
          @(negedge clk);
          k++;
        end
        check_eq("glitch_busy_rise", 32'(busy_o), 32'd1);
        while (busy_o === 1'b1 && n < 500) begin
          @(negedge clk);
          n++;
        end
        check_eq("glitch_busy_cycles", 32'(n), 32'd52);
      end
    join
    repeat (104) @(negedge clk);
    check_all("glitch");

    // Receiver disabled mid-frame: abort without push, then a clean frame
    set_cfg(16, 2'b11, 1'b0, 1'b0, 1'b0);
    drive_bit(1'b0);
    drive_bit(1'b1);
    drive_bit(1'b0);
    check_eq("abort_busy_before", 32'(busy_o), 32'd1);
    cfg_en_i = 1'b0;
    rx_i = 1'b1;
    repeat (4) @(negedge clk);
    check_all("abort");
    repeat (32) @(negedge clk);
    cfg_en_i = 1'b1;
    repeat (16) @(negedge clk);
    send_frame(8'h96, 1'b0, 1'b0, 1'b0);
    model_frame(8'h96, 1'b0, 1'b0, 1'b0);
    check_all("abort_next");
    drain("abort_next", 1);

    // 8N2 0xC3 with bad second stop, then 0x3C
    set_cfg(104, 2'b11, 1'b0, 1'b0, 1'b1);
    send_frame(8'hC3, 1'b0, 1'b0, 1'b1);
    model_frame(8'hC3, 1'b0, 1'b0, 1'b1);
    check_eq("8n2_errfrm", 32'(err_frame_o), 32'd1);
    check_eq("8n2_level0", 32'(fifo_level_o), 32'd0);
    send_frame(8'h3C, 1'b0, 1'b0, 1'b0);
    model_frame(8'h3C, 1'b0, 1'b0, 1'b0);
    check_eq("8n2_data", 32'(u_if.rx_data_o), 32'h3C);
    check_all("8n2");

    // Reset pulse during data bit 4, then 0xA5 received normally
    set_cfg(104, 2'b11, 1'b0, 1'b0, 1'b0);
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(i[0] ? 1'b0 : 1'b1);
    rx_i = 1'b0;
    repeat (52) @(negedge clk);
    check_eq("rst_mid_busy_before", 32'(busy_o), 32'd1);
    rstn_i = 1'b0;
    rx_i = 1'b1;
    #1;
    check_reset_vals("rst_mid");
    repeat (3) @(negedge clk);
    rstn_i = 1'b1;
    q.delete();
    exp_par = 1'b0; exp_frm = 1'b0; exp_ovf = 1'b0;
    repeat (208) @(negedge clk);
    check_all("rst_idle");
    send_frame(8'hA5, 1'b0, 1'b0, 1'b0);
    model_frame(8'hA5, 1'b0, 1'b0, 1'b0);
    check_eq("rst_next_data", 32'(u_if.rx_data_o), 32'hA5);
    check_all("rst_next");
    drain("rst_next", 1);

    // Randomized frames against the model
    for (int it = 0; it < 40; it++) begin
      int dv;
      logic [1:0] bb;
      bit pe, po, s2, fl, b1, b2;
      logic [7:0] d;
      dv = $urandom_range(24, 10);
      bb = 2'($urandom_range(3, 0));
      pe = 1'($urandom_range(1, 0));
      po = 1'($urandom_range(1, 0));
      s2 = 1'($urandom_range(1, 0));
      fl = pe && ($urandom_range(4, 0) == 0);
      b1 = ($urandom_range(7, 0) == 0);
      b2 = s2 && ($urandom_range(7, 0) == 0);
      d = 8'($urandom_range(255, 0));
      set_cfg(dv, bb, pe, po, s2);
      send_frame(d, fl, b1, b2);
      model_frame(d, fl, b1, b2);
      check_all($sformatf("rnd%0d", it));
      if ($urandom_range(2, 0) == 0) drain($sformatf("rnd%0d", it), $urandom_range(q.size(), 0));
      if ($urandom_range(3, 0) == 0) clear_err();
    end
    drain("final", q.size());
    check_all("final");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
